// File: rtl/seg_display_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_display_arbiter_if -- requester/display bundle for the display arbiter|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface seg_display_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    grant;
  logic [15:0]           disp_data;
  logic [2:0]            owner_id;
  logic                  busy;

  modport master (
    output req, req_data,
    input  grant, disp_data, owner_id, busy
  );

  modport slave (
    input  req, req_data,
    output grant, disp_data, owner_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/seg_display_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_display_arbiter -- round-robin 7-seg sharing with min hold; optional  |
// | idle blanking via SEG_ARB_IDLE_BLANK_EN.                   Rev 1.0        |
// +--------------------------------------------------------------------------+
module seg_display_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int HOLD_CYCLES       = 100000000,
  parameter int CNT_W             = 27,
  parameter int IDLE_BLANK_CYCLES = 50000000
) (
  input  logic                 clk,
  input  logic                 reset,
  seg_display_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_CYCLES < 1 || IDLE_BLANK_CYCLES < 1 ||
      CNT_W < 1 || CNT_W > 31 || ((HOLD_CYCLES - 1) >> CNT_W) != 0 ||
      ((IDLE_BLANK_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_params
    $error("seg_display_arbiter: illegal parameter set");
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t             r_state, w_state;
  logic [NUM_REQ-1:0] r_grant, w_grant;
  logic [15:0]        r_disp, w_disp;
  logic [2:0]         r_owner, w_owner;
  logic               r_busy, w_busy;
  logic [2:0]         r_last, w_last;
  logic [CNT_W-1:0]   r_tenure, w_tenure;

  logic [7:0]         w_req_ext;
  logic [15:0]        w_data [8];
  logic [3:0]         w_cand;
  logic               w_found;
  logic [2:0]         w_winner;
  logic [NUM_REQ-1:0] w_grant_new;
  logic               w_own_req;
  logic               w_others;
  logic               w_expired;
  logic               w_take;

  assign w_req_ext = 8'(bus.req);

  // Pad the per-requester data to 8 slots so owner/winner can index uniformly.
  for (genvar gi = 0; gi < 8; gi++) begin : g_data
    if (gi < NUM_REQ) begin : g_used
      assign w_data[gi] = bus.req_data[16*gi +: 16];
    end else begin : g_unused
      assign w_data[gi] = 16'h0000;
    end
  end

  // Walk from the farthest offset back to the nearest so the nearest set bit
  // after last_owner is what remains; offset NUM_REQ is last_owner itself.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 3'd0;
    w_cand   = 4'd0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_cand = 4'(r_last) + 4'(i);
      if (w_cand >= 4'(NUM_REQ)) w_cand = w_cand - 4'(NUM_REQ);
      if (w_req_ext[w_cand[2:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[2:0];
      end
    end
  end

  assign w_grant_new = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
  assign w_own_req   = w_req_ext[r_owner];
  assign w_others    = |(w_req_ext & ~(8'b1 << r_owner));
  assign w_expired   = (r_tenure == c_HOLD_LAST);

`ifdef SEG_ARB_IDLE_BLANK_EN
  localparam logic [CNT_W-1:0] c_IDLE_LAST = CNT_W'(IDLE_BLANK_CYCLES - 1);
  logic [CNT_W-1:0] r_idle, w_idle;
`endif

  always_comb begin
    w_state  = r_state;
    w_grant  = r_grant;
    w_disp   = r_disp;
    w_owner  = r_owner;
    w_busy   = r_busy;
    w_last   = r_last;
    w_tenure = r_tenure;
    w_take   = 1'b0;
`ifdef SEG_ARB_IDLE_BLANK_EN
    w_idle   = r_idle;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_take = 1'b1;
        end
`ifdef SEG_ARB_IDLE_BLANK_EN
        else if (r_idle == c_IDLE_LAST) begin
          w_disp = 16'h0000;
        end else begin
          w_idle = r_idle + 1'b1;
        end
`endif
      end
      S_OWN: begin
        if (!w_own_req) begin
          if (w_found) begin
            w_take = 1'b1;
          end else begin
            w_state = S_IDLE;
            w_grant = '0;
            w_busy  = 1'b0;
`ifdef SEG_ARB_IDLE_BLANK_EN
            w_idle  = '0;
`endif
          end
        end else if (w_expired && w_others) begin
          w_take = 1'b1;
        end else begin
          w_disp = w_data[r_owner];
          if (!w_expired) w_tenure = r_tenure + 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_grant = '0;
        w_busy  = 1'b0;
      end
    endcase
    if (w_take) begin
      w_state  = S_OWN;
      w_grant  = w_grant_new;
      w_owner  = w_winner;
      w_last   = w_winner;
      w_busy   = 1'b1;
      w_disp   = w_data[w_winner];
      w_tenure = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_disp   <= 16'h0000;
      r_owner  <= 3'd0;
      r_busy   <= 1'b0;
      r_last   <= 3'(NUM_REQ - 1);
      r_tenure <= '0;
    end else begin
      r_state  <= w_state;
      r_grant  <= w_grant;
      r_disp   <= w_disp;
      r_owner  <= w_owner;
      r_busy   <= w_busy;
      r_last   <= w_last;
      r_tenure <= w_tenure;
    end
  end

`ifdef SEG_ARB_IDLE_BLANK_EN
  always_ff @(posedge clk) begin
    if (reset) r_idle <= '0;
    else       r_idle <= w_idle;
  end
`endif

  assign bus.grant     = r_grant;
  assign bus.disp_data = r_disp;
  assign bus.owner_id  = r_owner;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg_display_arbiter -- scoreboard bench, NUM_REQ=4, HOLD_CYCLES=4     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_seg_display_arbiter;

  logic clk;
  logic reset;

  seg_display_arbiter_if #(.NUM_REQ(4)) bus ();

  seg_display_arbiter #(
    .NUM_REQ          (4),
    .HOLD_CYCLES      (4),
    .CNT_W            (27),
    .IDLE_BLANK_CYCLES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  grant;
    logic [2:0]  owner;
    logic        busy;
    logic [15:0] disp;
  } exp_t;

  exp_t        r_sb [$];
  logic [15:0] r_d [4];
  int          r_n_vec  = 0;
  int          r_n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    r_n_vec++;
    if (obs !== expv) begin
      r_n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input exp_t e, input bit chk_owner);
    chk("grant", 32'(bus.grant), 32'(e.grant));
    chk("busy", 32'(bus.busy), 32'(e.busy));
    chk("disp", 32'(bus.disp_data), 32'(e.disp));
    if (chk_owner) chk("owner", 32'(bus.owner_id), 32'(e.owner));
    chk("invariant", 32'($onehot0(bus.grant) && ((bus.grant != 4'b0) == bus.busy)), 32'd1);
  endtask

  task automatic apply(input logic [3:0] req, input logic [3:0] eg, input logic [2:0] eo,
                       input logic eb, input logic [15:0] ed);
    exp_t e;
    bus.req      = req;
    bus.req_data = {r_d[3], r_d[2], r_d[1], r_d[0]};
    r_sb.push_back('{grant: eg, owner: eo, busy: eb, disp: ed});
    @(posedge clk);
    #1;
    if (r_sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = r_sb.pop_front();
      check_outputs(e, eb);
    end
  endtask

  task automatic do_reset(input logic [3:0] req);
    reset        = 1'b1;
    bus.req      = req;
    bus.req_data = {r_d[3], r_d[2], r_d[1], r_d[0]};
    @(posedge clk);
    #1;
    check_outputs('{grant: 4'b0, owner: 3'd0, busy: 1'b0, disp: 16'h0000}, 1'b1);
    reset = 1'b0;
  endtask

  initial begin
    int o;
    r_d[0] = 16'h1234; r_d[1] = 16'hB111; r_d[2] = 16'hC222; r_d[3] = 16'hD333;
    reset        = 1'b1;
    bus.req      = 4'b0;
    bus.req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(4'b0000);

    // Plan 1: first grant and live data tracking
    apply(4'b0001, 4'b0001, 3'd0, 1'b1, 16'h1234);
    r_d[0] = 16'h5678;
    apply(4'b0001, 4'b0001, 3'd0, 1'b1, 16'h5678);
    apply(4'b0000, 4'b0000, 3'd0, 1'b0, 16'h5678);
    apply(4'b0000, 4'b0000, 3'd0, 1'b0, 16'h5678);

    // Plan 2: round robin 0 -> 1 -> 3 -> 0, four cycles each, no gaps
    do_reset(4'b0000);
    for (int k = 0; k < 16; k++) begin
      o = (k < 4) ? 0 : (k < 8) ? 1 : (k < 12) ? 3 : 0;
      apply(4'b1011, 4'b0001 << o, 3'(o), 1'b1, r_d[o]);
    end
    apply(4'b0000, 4'b0000, 3'd0, 1'b0, r_d[0]);

    // Plan 3: early release hands over directly
    apply(4'b0100, 4'b0100, 3'd2, 1'b1, r_d[2]);
    apply(4'b0010, 4'b0010, 3'd1, 1'b1, r_d[1]);
    apply(4'b0000, 4'b0000, 3'd1, 1'b0, r_d[1]);

    // Plan 4: sole requester stays past expiry
    for (int k = 0; k < 20; k++) apply(4'b1000, 4'b1000, 3'd3, 1'b1, r_d[3]);
    apply(4'b0000, 4'b0000, 3'd3, 1'b0, r_d[3]);

    // Plan 5: reset during ownership, then requester 0 wins first
    r_d[1] = 16'hABCD;
    apply(4'b0010, 4'b0010, 3'd1, 1'b1, 16'hABCD);
    apply(4'b0010, 4'b0010, 3'd1, 1'b1, 16'hABCD);
    do_reset(4'b1111);
    for (int k = 0; k < 5; k++) begin
      o = (k < 4) ? 0 : 1;
      apply(4'b1111, 4'b0001 << o, 3'(o), 1'b1, r_d[o]);
    end
    apply(4'b0000, 4'b0000, 3'd1, 1'b0, 16'hABCD);

    // Plan 6: idle hold / blanking
    r_d[0] = 16'h00C3;
    apply(4'b0001, 4'b0001, 3'd0, 1'b1, 16'h00C3);
    for (int k = 0; k < 8; k++) apply(4'b0000, 4'b0000, 3'd0, 1'b0, 16'h00C3);
`ifdef SEG_ARB_IDLE_BLANK_EN
    apply(4'b0000, 4'b0000, 3'd0, 1'b0, 16'h0000);
    apply(4'b0000, 4'b0000, 3'd0, 1'b0, 16'h0000);
`else
    apply(4'b0000, 4'b0000, 3'd0, 1'b0, 16'h00C3);
    apply(4'b0000, 4'b0000, 3'd0, 1'b0, 16'h00C3);
`endif
    apply(4'b0001, 4'b0001, 3'd0, 1'b1, 16'h00C3);

    $display("== %0d vectors applied, %0d miscompares ==", r_n_vec, r_n_miss);
    $finish;
  end

endmodule
`default_nettype wire
